// File: rtl/vga_bus_capture.sv
// Oversampling capture of 6502 writes to the VGA register block. Qualified
// write cycles are queued as {REG,DATA} commands behind a valid/ready head.
module vga_bus_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 3,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK_FAST,
  input  logic              RESET,
  input  logic              CLK_CPU,
  input  logic              EN,
  input  logic              RW,
  input  logic [2:0]        REG,
  input  logic [7:0]        DATA,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int BUS_W = 14;
  localparam int CNT_W = (MIN_HIGH < 1) ? 1 : $clog2(MIN_HIGH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MIN_HIGH);
  localparam logic [ADDR_W:0]   LEVEL_MAX = (ADDR_W + 1)'(DEPTH);

  // Bus synchronizer: all 14 lines share one chain so they stay aligned.
  logic [BUS_W-1:0] sync_q [SYNC_STAGES];
  logic             phi2_s, en_s, rw_s;
  logic [2:0]       reg_s;
  logic [7:0]       data_s;

  always_ff @(posedge CLK_FAST) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {CLK_CPU, EN, RW, REG, DATA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {phi2_s, en_s, rw_s, reg_s, data_s} = sync_q[SYNC_STAGES-1];

  // The chain output is only real once it has refilled after reset, and the
  // first cycle that may qualify must begin with a genuine low phase.
  logic [SYNC_STAGES-1:0] primed;
  logic                   armed;
  logic                   phi2_prev;
  logic [CNT_W-1:0]       high_cnt;
  logic                   lat_wr;
  logic [2:0]             lat_reg;
  logic [7:0]             lat_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge CLK_FAST) begin
    if (RESET) begin
      primed    <= '0;
      armed     <= 1'b0;
      phi2_prev <= 1'b0;
      high_cnt  <= '0;
      lat_wr    <= 1'b0;
      lat_reg   <= '0;
      lat_data  <= '0;
    end else begin
      primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
      phi2_prev <= phi2_s;
      if (primed[SYNC_STAGES-1] && !phi2_s) armed <= 1'b1;
      if (phi2_s) begin
        if (high_cnt != CNT_MAX) high_cnt <= high_cnt + CNT_W'(1);
        lat_reg  <= reg_s;
        lat_data <= data_s;
        lat_wr   <= ~en_s & ~rw_s;
      end else begin
        high_cnt <= '0;
      end
    end
  end

  logic              fall, wr_qual, pop, push, drop;
  logic [ADDR_W-1:0] wptr, rptr, rptr_next;
  logic [ADDR_W:0]   level_next, head_left;

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    fall       = 1'b0;
    wr_qual    = 1'b0;
    fall       = phi2_prev & ~phi2_s;
    wr_qual    = fall & lat_wr & armed & (high_cnt >= CNT_MAX);
    pop        = cmd_valid & cmd_ready;
    push       = wr_qual & (~fifo_full | pop);
    drop       = wr_qual & fifo_full & ~pop;
    rptr_next  = rptr + ADDR_W'(pop);
    level_next = fifo_level + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    head_left  = fifo_level - (ADDR_W + 1)'(pop);
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // define which words are meaningful, and a reset would block RAM inference.
  logic [10:0] mem [DEPTH];

  always_ff @(posedge CLK_FAST) begin
    if (push) mem[wptr] <= {lat_reg, lat_data};
  end

  // Head register is reloaded from storage every cycle; it reads the entry
  // that remains at the front after this cycle's pop, giving back-to-back pops.
  always_ff @(posedge CLK_FAST) begin
    if (RESET) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_reg    <= '0;
      cmd_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      rptr       <= rptr_next;
      fifo_level <= level_next;
      fifo_full  <= (level_next == LEVEL_MAX);
      cmd_valid  <= (head_left != '0);
      if (head_left != '0) {cmd_reg, cmd_data} <= mem[rptr_next];
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_bus_capture.sv
// Randomized bench for vga_bus_capture: a queue model predicts the command
// stream while a negedge monitor compares every popped head against it.
module tb_vga_bus_capture;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_HIGH    = 3;
  localparam int DEPTH       = 256;
  localparam int ADDR_W      = 8;

  logic              clk;
  logic              RESET;
  logic              CLK_CPU, EN, RW;
  logic [2:0]        REG;
  logic [7:0]        DATA;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_reg;
  logic [7:0]        cmd_data;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_full, overflow, overflow_clr;

  vga_bus_capture #(
    .SYNC_STAGES(SYNC_STAGES), .MIN_HIGH(MIN_HIGH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .CLK_FAST(clk), .RESET(RESET), .CLK_CPU(CLK_CPU), .EN(EN), .RW(RW),
    .REG(REG), .DATA(DATA), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] r;
    logic [7:0] d;
  } entry_t;

  entry_t exp_q[$];
  bit     exp_ovf;
  int     checks = 0;
  int     errors = 0;
  bit     rnd_ready = 0;
  entry_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready here.
  always @(negedge clk) begin
    if (!RESET && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got reg %0h data %0h expected no entry", cmd_reg, cmd_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_reg", 32'(cmd_reg), 32'(mon_e.r));
        check("pop_data", 32'(cmd_data), 32'(mon_e.d));
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  // One 6502 bus cycle: setup during low phase, phi2 high for hi fast cycles,
  // then the bus changes one fast cycle after the fall.
  task automatic bus_cycle(input logic en, input logic rw, input logic [2:0] r,
                           input logic [7:0] d, input int hi, input int lo,
                           input bit pop_same);
    @(posedge clk); #3;
    EN = en; RW = rw; REG = r; DATA = d;
    repeat (2) @(posedge clk);
    #3 CLK_CPU = 1'b1;
    repeat (hi) @(posedge clk);
    #3 CLK_CPU = 1'b0;
    if (!en && !rw && hi >= MIN_HIGH) begin
      if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(entry_t'{r: r, d: d});
      else exp_ovf = 1'b1;
    end
    @(posedge clk); #3;
    DATA = ~d; EN = 1'b1; RW = 1'b1;
    if (pop_same) begin
      repeat (SYNC_STAGES - 1) @(posedge clk);
      #3 cmd_ready = 1'b1;
      @(posedge clk);
      #3 cmd_ready = 1'b0;
    end
    repeat (lo) @(posedge clk);
  endtask

  task automatic settle();
    repeat (SYNC_STAGES + 4) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input bit check_bubbles);
    int n, bubbles, guard;
    n = exp_q.size();
    bubbles = 0;
    guard = 0;
    @(posedge clk); #3 cmd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!cmd_valid) bubbles++;
    end
    while (exp_q.size() > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #3 cmd_ready = 1'b0;
    settle();
    if (check_bubbles) check({name, "_bubbles"}, 32'(bubbles), 0);
    check({name, "_left"}, 32'(exp_q.size()), 0);
    check({name, "_level"}, 32'(fifo_level), 0);
    check({name, "_valid"}, 32'(cmd_valid), 0);
  endtask

  initial begin
    int lat;
    bit found;
    RESET = 1'b1; CLK_CPU = 1'b0; EN = 1'b1; RW = 1'b1; REG = '0; DATA = '0;
    cmd_ready = 1'b0; overflow_clr = 1'b0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_head", 32'({cmd_reg, cmd_data}), 0);
    #2 RESET = 1'b0;
    repeat (4) @(posedge clk);

    // Single write with latency measurement from the phi2 fall.
    bus_cycle(1'b0, 1'b0, 3'd3, 8'h41, 20, 0, 1'b0);
    found = 0;
    lat = 0;
    for (int k = 2; k <= SYNC_STAGES + 5; k++) begin
      @(posedge clk); #1;
      if (cmd_valid && !found) begin
        found = 1;
        lat = k;
      end
    end
    check("single_latency_ok", 32'(found && lat <= SYNC_STAGES + 2), 1);
    check("single_level", 32'(fifo_level), 32'(exp_q.size()));
    check("single_reg", 32'(cmd_reg), 32'(exp_q[0].r));
    check("single_data", 32'(cmd_data), 32'(exp_q[0].d));
    repeat (10) @(posedge clk);
    #1 check("single_hold", 32'({cmd_valid, cmd_reg, cmd_data}), 32'({1'b1, exp_q[0].r, exp_q[0].d}));
    drain("single", 1'b0);

    // Filtered cycles: read, deselected write, short phi2 pulse.
    bus_cycle(1'b0, 1'b1, 3'd1, 8'h11, 6, 3, 1'b0);
    bus_cycle(1'b1, 1'b0, 3'd2, 8'h22, 6, 3, 1'b0);
    bus_cycle(1'b0, 1'b0, 3'd4, 8'h33, MIN_HIGH - 1, 3, 1'b0);
    settle();
    check("filter_level", 32'(fifo_level), 32'(exp_q.size()));
    check("filter_valid", 32'(cmd_valid), 0);

    // Data changes one fast cycle after the fall: the in-phase byte is kept.
    bus_cycle(1'b0, 1'b0, 3'd5, 8'h55, 6, 4, 1'b0);
    settle();
    check("hold_time_data", 32'(cmd_data), 32'(exp_q[0].d));
    drain("hold_time", 1'b0);

    // Burst to full, overflow, clear, then a write with pop while full.
    for (int i = 0; i < DEPTH; i++) bus_cycle(1'b0, 1'b0, 3'(i % 8), 8'(i), 4, 2, 1'b0);
    settle();
    check("burst_level", 32'(fifo_level), DEPTH);
    check("burst_full", 32'(fifo_full), 1);
    check("burst_head", 32'(cmd_data), 32'(exp_q[0].d));
    bus_cycle(1'b0, 1'b0, 3'd7, 8'hEE, 5, 3, 1'b0);
    settle();
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_level", 32'(fifo_level), 32'(exp_q.size()));
    check("ovf_head", 32'({cmd_reg, cmd_data}), 32'({exp_q[0].r, exp_q[0].d}));
    @(posedge clk); #3 overflow_clr = 1'b1;
    @(posedge clk); #3 overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    #1 check("ovf_clear", 32'(overflow), 32'(exp_ovf));
    bus_cycle(1'b0, 1'b0, 3'd6, 8'h99, 5, 3, 1'b1);
    settle();
    check("full_pop_level", 32'(fifo_level), 32'(exp_q.size()));
    check("full_pop_ovf", 32'(overflow), 32'(exp_ovf));
    check("full_pop_head", 32'(cmd_data), 32'(exp_q[0].d));
    drain("burst", 1'b1);

    // Random mix of qualifying and filtered cycles under random back-pressure.
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: bus_cycle(1'b0, 1'b0, 3'($urandom), 8'($urandom), $urandom_range(MIN_HIGH, 8), $urandom_range(1, 4), 1'b0);
        2:    bus_cycle(1'($urandom_range(0, 1)), 1'b1, 3'($urandom), 8'($urandom), $urandom_range(3, 8), $urandom_range(1, 4), 1'b0);
        default: bus_cycle(1'b0, 1'b0, 3'($urandom), 8'($urandom), $urandom_range(1, MIN_HIGH - 1), $urandom_range(1, 4), 1'b0);
      endcase
    end
    rnd_ready = 0;
    @(posedge clk);
    drain("random", 1'b0);
    check("random_ovf", 32'(overflow), 32'(exp_ovf));

    // Reset while a write is in its high phase with entries queued.
    for (int i = 0; i < 5; i++) bus_cycle(1'b0, 1'b0, 3'($urandom), 8'($urandom), 5, 2, 1'b0);
    settle();
    check("pre_reset_level", 32'(fifo_level), 32'(exp_q.size()));
    @(posedge clk); #3;
    EN = 1'b0; RW = 1'b0; REG = 3'd2; DATA = 8'h77;
    repeat (2) @(posedge clk);
    #3 CLK_CPU = 1'b1;
    repeat (4) @(posedge clk);
    #3 RESET = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_valid", 32'(cmd_valid), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    #2 RESET = 1'b0;
    repeat (10) @(posedge clk);
    #3 CLK_CPU = 1'b0;
    @(posedge clk); #3;
    DATA = 8'h00; EN = 1'b1; RW = 1'b1;
    settle();
    check("inflight_dropped_level", 32'(fifo_level), 32'(exp_q.size()));
    check("inflight_dropped_valid", 32'(cmd_valid), 0);
    bus_cycle(1'b0, 1'b0, 3'd1, 8'hC3, 6, 3, 1'b0);
    settle();
    check("post_rst_level", 32'(fifo_level), 32'(exp_q.size()));
    check("post_rst_head", 32'({cmd_reg, cmd_data}), 32'({exp_q[0].r, exp_q[0].d}));
    drain("post_rst", 1'b0);

    check("final_scoreboard", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_bus_capture.md
Name: vga_bus_capture

Overview:
- Front end of the VGA register interface. It sits between the 6502 bus pins and the VGA command processor.
- Oversamples the CPU bus (CLK_CPU/phi2, EN, RW, REG, DATA) in the CLK_FAST domain and qualifies complete write cycles.
- Pushes each qualified write as an 11-bit {REG,DATA} command into a FIFO.
- Presents the FIFO head to the command processor over a valid/ready handshake.
- Replaces asynchronous capture of writes on a bus strobe edge.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on CLK_CPU/EN/RW/REG/DATA (min 2).
- MIN_HIGH, 3, minimum consecutive CLK_FAST cycles phi2 must be high for the cycle to qualify (glitch filter).
- DEPTH, 256, FIFO entries (power of two).
- ADDR_W, 8, log2(DEPTH).

Ports:
- CLK_FAST input 1: single clock, rising edge.
- RESET input 1: synchronous, active-high reset.
- CLK_CPU input 1: 6502 phi2, asynchronous.
- EN input 1: chip select, active low, asynchronous.
- RW input 1: 1=read, 0=write, asynchronous.
- REG input 3: register select, asynchronous.
- DATA input 8: CPU data bus, asynchronous.
- cmd_valid output 1: FIFO head valid.
- cmd_ready input 1: consumer accepts head.
- cmd_reg output 3: head register index.
- cmd_data output 8: head data byte.
- fifo_level output ADDR_W+1: entries stored, 0..DEPTH.
- fifo_full output 1: fifo_level==DEPTH.
- overflow output 1: sticky, a write was dropped.
- overflow_clr input 1: clears overflow.

Behaviour:
- Reset (RESET high at a CLK_FAST edge):
  - All outputs 0.
  - FIFO pointers and level 0.
  - Synchronizer chains, high counter and latches cleared.
  - An in-flight CPU cycle is discarded. Capture resumes on the first phi2 rising edge seen after reset.
- Synchronization:
  - All 14 bus inputs pass through identical SYNC_STAGES chains, giving phi2_s, en_s, rw_s, reg_s, data_s mutually aligned.
- High counter:
  - Saturating counter, width ≥ clog2(MIN_HIGH+1).
  - Increments while phi2_s=1; cleared when phi2_s=0.
- Sample latch:
  - Every cycle with phi2_s=1: lat_reg<=reg_s, lat_data<=data_s, lat_wr<=(~en_s & ~rw_s).
  - The latch therefore holds the last in-phase sample before phi2 falls.
- Falling-edge detect:
  - Fires in cycle E where phi2_s=0 and phi2_s_prev=1.
  - Qualified write = fall & lat_wr & (high_cnt_prev ≥ MIN_HIGH).
  - Read cycles, deselected cycles and short phi2 pulses produce nothing.
- Push:
  - A qualified write is pushed into mem[wptr] in cycle E.
  - Pointers are ADDR_W bits and wrap naturally DEPTH-1→0.
- FIFO output:
  - First-word-fall-through with registered outputs. An entry pushed into an empty FIFO at edge E shows cmd_valid=1 after edge E+1.
  - Total latency from the raw CLK_CPU fall to cmd_valid is at most SYNC_STAGES+2 CLK_FAST cycles.
  - Pop when cmd_valid & cmd_ready. The next entry (if any) is presented on the following edge with no bubble.
  - cmd_reg/cmd_data hold stable while cmd_valid=1 & cmd_ready=0.
  - cmd_ready while cmd_valid=0 is ignored.
- Level:
  - fifo_level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - It counts the presented head entry.
- Full:
  - A push while fifo_full=1 with no pop in the same cycle is dropped, and overflow<=1. Stored data is unaffected.
  - Push and pop in the same cycle while full: both succeed, the level stays DEPTH, no overflow.
- Empty:
  - A pop with cmd_valid=0 cannot occur and never underflows.
  - Push into an empty FIFO with a simultaneous cmd_ready has no effect on that new entry until it is presented.
- overflow_clr:
  - Clears overflow.
  - If overflow_clr and a drop happen in the same cycle, the drop wins and overflow stays 1.
- Throughput:
  - At most one push per phi2 period.
  - The consumer may pop every cycle.

Test Plan:
- Single write:
  - Stimulus: one 6502 write cycle, REG=3, DATA=0x41, phi2 high for 20 CLK_FAST cycles, cmd_ready=0.
  - Required: exactly one entry, cmd_valid=1, cmd_reg=3, cmd_data=0x41, fifo_level=1, within SYNC_STAGES+2 cycles of the phi2 fall. The entry holds until cmd_ready=1, then cmd_valid=0 and level=0.
- Filtered cycles:
  - Stimulus: a read cycle (RW=1), a deselected write (EN=1), and a write with a phi2 pulse 2 cycles wide (MIN_HIGH=3).
  - Required: fifo_level stays 0 and cmd_valid stays 0.
- Burst and ordering:
  - Stimulus: 256 writes, DATA=0x00..0xFF with REG=i%8, cmd_ready=0.
  - Required: fifo_full=1, level=256. Drain with cmd_ready=1: entries come out in order with no bubbles, final level=0.
- Overflow:
  - Stimulus: a 257th write while full.
  - Required: dropped, overflow=1, head still 0x00. Then overflow_clr for 1 cycle gives overflow=0.
  - Stimulus: a write while full with cmd_ready=1 in the push cycle.
  - Required: accepted, level stays 256, overflow=0.
- Data timing:
  - Stimulus: DATA changes from 0x55 to 0xAA 1 CLK_FAST cycle after the phi2 fall (hold violation in the fast domain).
  - Required: captured byte is 0x55.
- Reset mid-operation:
  - Stimulus: 5 entries queued, RESET asserted while phi2 is high on a write.
  - Required: level=0, cmd_valid=0, overflow=0, and that write is not captured. The next full write after reset is captured normally.
